register_block: RTL and testbench
=================================

REGISTER_BLOCK -- requirements
Module: register_block

Interface
REQ-001 Parameter DATA_W, default 8: register and data-port width in bits.
REQ-002 Parameter ID_W, default 4: register-identifier width in bits.
REQ-003 Parameter NUM_REGS, default 8: number of implemented registers, ids 0..NUM_REGS-1; must be at most 2**ID_W.
REQ-004 Port: clock  input  1  the block's single clock; all register updates occur on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: read1_id  input  ID_W  register selector for read port 1.
REQ-007 Port: read1_value  output  DATA_W  contents of the register selected by read1_id.
REQ-008 Port: read2_id  input  ID_W  register selector for read port 2.
REQ-009 Port: read2_value  output  DATA_W  contents of the register selected by read2_id.
REQ-010 Port: write_id  input  ID_W  register selector for the write port.
REQ-011 Port: write_value  input  DATA_W  data to be written.
REQ-012 Port: write_en  input  1  write qualifier; a write occurs only when it is 1.

Function
REQ-013 Read ports SHALL be combinational (zero latency) and fully independent; both may select the same id.
REQ-014 When write_en=1 at a rising edge of clock and write_id < NUM_REGS, register[write_id] SHALL load write_value; the new value is visible on the read ports after that edge.
REQ-015 A write with write_id >= NUM_REGS SHALL be ignored and SHALL leave every register unchanged.
REQ-016 A read with id >= NUM_REGS SHALL return all zeros.
REQ-017 With write_en=0, all registers SHALL hold their values.
REQ-018 Only the addressed register SHALL change on a write; all others are untouched.
REQ-019 X or Z on write_id or write_value while write_en=0 SHALL have no effect on stored state.

Reset
REQ-020 While reset=1, all registers SHALL be asynchronously forced to 0, independent of clock, so both read ports return 0.
REQ-021 Reset SHALL take priority over a write in the same cycle; the first write is accepted on the first rising edge after reset deasserts.

Configuration
REQ-022 Macro REGISTER_BLOCK_BYPASS_EN, when defined: if write_en=1, write_id < NUM_REGS, and a read id equals write_id, that read port SHALL return write_value combinationally in the same cycle.
REQ-023 Without REGISTER_BLOCK_BYPASS_EN, a read port SHALL return the stored (pre-edge) value until the write's rising edge.
REQ-024 Bypass SHALL never apply while reset=1.

Structure
REQ-025 Package register_block_pkg SHALL hold the default DATA_W, ID_W, and NUM_REGS constants and a data-word typedef.
REQ-026 Each register SHALL be an instance of sub-module register_cell, a DATA_W-bit flop with asynchronous reset and load enable.
REQ-027 register_block SHALL contain the write decode, the NUM_REGS register_cell instances, and two read multiplexers with out-of-range zeroing.

Verification
REQ-028 Apply reset, release it, set read1_id=3 and read2_id=4 -> read1_value=0x00 and read2_value=0x00.
REQ-029 Set read1_id=14 (out of range) -> read1_value=0x00; then write id 14 with 0xFF -> read1_value is still 0x00 and ids 0..7 are unchanged.
REQ-030 Write id 2 with 0x55 (write_en=1, one rising edge), read1_id=2 -> read1_value=0x55; read1_id=3 -> 0x00.
REQ-031 Write id 5 with 0xA3, then read1_id=5 and read2_id=5 -> both ports return 0xA3.
REQ-032 With write_en=0, write_id=2, write_value=0x00, apply a clock edge -> register 2 still reads 0x55; then assert reset mid-cycle -> all reads return 0x00 immediately.
REQ-033 With the macro defined, drive write id 6 with 0x3C and read1_id=6 before the edge -> read1_value=0x3C; with the macro undefined -> 0x00 before the edge and 0x3C after it.

Source files
------------

// File: rtl/register_block_pkg.sv
// Shared constants and types for the register block.
// Optional macro: REGISTER_BLOCK_BYPASS_EN (write-to-read forwarding).
package register_block_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ID_W     = 4;
    localparam int DEF_NUM_REGS = 8;

    typedef logic [DEF_DATA_W-1:0] data_t;
endpackage

// File: rtl/register_block_if.sv
// Read/write bus of the register block: two read ports, one write port.
interface register_block_if
    import register_block_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W   = DEF_ID_W
);
    logic [ID_W-1:0]   read1_id;
    logic [DATA_W-1:0] read1_value;
    logic [ID_W-1:0]   read2_id;
    logic [DATA_W-1:0] read2_value;
    logic [ID_W-1:0]   write_id;
    logic [DATA_W-1:0] write_value;
    logic              write_en;

    modport master (
        output read1_id, read2_id,
        output write_id, write_value, write_en,
        input  read1_value, read2_value
    );

    modport slave (
        input  read1_id, read2_id,
        input  write_id, write_value, write_en,
        output read1_value, read2_value
    );
endinterface

// File: rtl/register_cell.sv
// One storage word: async-reset flop with load enable.
module register_cell
    import register_block_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_q <= '0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/register_block.sv
// Register file: NUM_REGS cells, one write port, two combinational reads.
// Optional macro: REGISTER_BLOCK_BYPASS_EN forwards write data to reads.
module register_block
    import register_block_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ID_W     = DEF_ID_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic            clock,
    input  logic            reset,
    register_block_if.slave bus
);
    logic [NUM_REGS-1:0] w_we;
    logic [DATA_W-1:0]   w_q [NUM_REGS];
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;

    // Ids outside 0..NUM_REGS-1 never match, so such writes are dropped.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_we[i] = bus.write_en && (bus.write_id == ID_W'(i));
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        register_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clock (clock),
            .reset (reset),
            .i_en  (w_we[g]),
            .i_d   (bus.write_value),
            .o_q   (w_q[g])
        );
    end

`ifdef REGISTER_BLOCK_BYPASS_EN
    logic [NUM_REGS-1:0] w_byp;
    assign w_byp = reset ? '0 : w_we;
`endif

    // Unmatched (out-of-range) ids fall through to the zero default.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.read1_id == ID_W'(i))
                w_rd1 = w_q[i];
            if (bus.read2_id == ID_W'(i))
                w_rd2 = w_q[i];
`ifdef REGISTER_BLOCK_BYPASS_EN
            if (w_byp[i] && bus.read1_id == ID_W'(i))
                w_rd1 = bus.write_value;
            if (w_byp[i] && bus.read2_id == ID_W'(i))
                w_rd2 = bus.write_value;
`endif
        end
    end

    assign bus.read1_value = w_rd1;
    assign bus.read2_value = w_rd2;
endmodule

// File: tb/tb_register_block.sv
// Scoreboard bench for register_block: expectations queued at drive time.
// Honours REGISTER_BLOCK_BYPASS_EN for same-cycle forwarding expectations.
module tb_register_block;
    import register_block_pkg::*;

    typedef struct {
        bit    port;
        data_t exp;
        string name;
    } sb_t;

    logic  clock = 1'b0;
    logic  reset = 1'b0;
    sb_t   sbq[$];
    sb_t   e;
    data_t obs;
    data_t mdl [8];
    int    n_checks = 0;
    int    n_pass   = 0;

    register_block_if #(.DATA_W(8), .ID_W(4)) bus ();

    register_block u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic void exp_push(bit port, data_t v, string n);
        sb_t s;
        s.port = port;
        s.exp  = v;
        s.name = n;
        sbq.push_back(s);
    endfunction

    task automatic do_write(logic [3:0] id, data_t v);
        @(negedge clock);
        bus.write_id    = id;
        bus.write_value = v;
        bus.write_en    = 1'b1;
        @(posedge clock);
        if (id < 4'd8)
            mdl[id[2:0]] = v;
        #1;
        bus.write_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.write_en    = 1'b0;
        bus.write_id    = '0;
        bus.write_value = '0;
        bus.read1_id    = 4'd0;
        bus.read2_id    = 4'd7;
        for (int i = 0; i < 8; i++)
            mdl[i] = '0;
        #3;
        exp_push(0, 8'h00, "async_reset_r1");
        exp_push(1, 8'h00, "async_reset_r2");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
        @(negedge clock);
        reset = 1'b0;
        bus.read1_id = 4'd3;
        bus.read2_id = 4'd4;
        #1;
        exp_push(0, 8'h00, "post_reset_r1_id3");
        exp_push(1, 8'h00, "post_reset_r2_id4");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        bus.read1_id = 4'd14;
        #1;
        exp_push(0, 8'h00, "oor_read_id14");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
        do_write(4'd14, 8'hFF);
        #1;
        exp_push(0, 8'h00, "oor_write_id14");
        for (int i = 0; i < 8; i++) begin
            bus.read2_id = 4'(i);
            #1;
            exp_push(1, mdl[i], $sformatf("oor_untouched_%0d", i));
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                obs = e.port ? bus.read2_value : bus.read1_value;
                n_checks++;
                if (obs !== e.exp)
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_write_read();
        do_write(4'd2, 8'h55);
        bus.read1_id = 4'd2;
        #1;
        exp_push(0, 8'h55, "write2_read2");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
        bus.read1_id = 4'd3;
        #1;
        exp_push(0, 8'h00, "write2_read3");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
    endtask

    task automatic test_dual_read();
        do_write(4'd5, 8'hA3);
        bus.read1_id = 4'd5;
        bus.read2_id = 4'd5;
        #1;
        exp_push(0, 8'hA3, "dual_r1_id5");
        exp_push(1, 8'hA3, "dual_r2_id5");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
    endtask

    task automatic test_hold_and_reset();
        @(negedge clock);
        bus.write_en    = 1'b0;
        bus.write_id    = 4'd2;
        bus.write_value = 8'h00;
        bus.read1_id    = 4'd2;
        @(posedge clock);
        @(negedge clock);
        bus.write_id    = 'x;
        bus.write_value = 'x;
        @(posedge clock);
        #1;
        exp_push(0, 8'h55, "hold_reg2");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
        @(negedge clock);
        bus.write_id    = 4'd1;
        bus.write_value = 8'h11;
        bus.read2_id    = 4'd5;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 8; i++)
            mdl[i] = '0;
        #1;
        exp_push(0, 8'h00, "midcycle_reset_r1");
        exp_push(1, 8'h00, "midcycle_reset_r2");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
        // Write held active through reset: must lose, then land after release.
        bus.write_en = 1'b1;
        bus.read1_id = 4'd1;
        @(posedge clock);
        #1;
        exp_push(0, 8'h00, "reset_beats_write");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        mdl[1] = 8'h11;
        #1;
        bus.write_en = 1'b0;
        #1;
        exp_push(0, 8'h11, "first_write_after_reset");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
    endtask

    task automatic test_bypass();
        @(negedge clock);
        bus.write_id    = 4'd6;
        bus.write_value = 8'h3C;
        bus.write_en    = 1'b1;
        bus.read1_id    = 4'd6;
        bus.read2_id    = 4'd7;
        #1;
`ifdef REGISTER_BLOCK_BYPASS_EN
        exp_push(0, 8'h3C, "bypass_before_edge");
`else
        exp_push(0, mdl[6], "no_bypass_before_edge");
`endif
        exp_push(1, mdl[7], "bypass_other_port");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
        @(posedge clock);
        mdl[6] = 8'h3C;
        #1;
        exp_push(0, 8'h3C, "after_edge_id6");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
        @(negedge clock);
        bus.write_value = 8'h99;
        reset = 1'b1;
        for (int i = 0; i < 8; i++)
            mdl[i] = '0;
        #1;
        exp_push(0, 8'h00, "no_bypass_in_reset");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = e.port ? bus.read2_value : bus.read1_value;
            n_checks++;
            if (obs !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            else
                n_pass++;
        end
        bus.write_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] wid;
        logic [3:0] rid;
        for (int n = 0; n < 32; n++) begin
            wid = 4'($urandom_range(0, 15));
            @(negedge clock);
            bus.write_id    = wid;
            bus.write_value = 8'($urandom_range(0, 255));
            bus.write_en    = 1'($urandom_range(0, 3) != 0);
            @(posedge clock);
            if (bus.write_en && wid < 4'd8)
                mdl[wid[2:0]] = bus.write_value;
            #1;
            bus.write_en = 1'b0;
            rid = 4'($urandom_range(0, 15));
            bus.read1_id = wid;
            bus.read2_id = rid;
            #1;
            exp_push(0, (wid < 4'd8) ? mdl[wid[2:0]] : 8'h00, "b2b_r1");
            exp_push(1, (rid < 4'd8) ? mdl[rid[2:0]] : 8'h00, "b2b_r2");
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                obs = e.port ? bus.read2_value : bus.read1_value;
                n_checks++;
                if (obs !== e.exp)
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                else
                    n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_of_range();
        test_write_read();
        test_dual_read();
        test_hold_and_reset();
        test_bypass();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
